// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI peripheral front-end.
//               Holds the transaction state enum, the byte width and the
//               saturation ceiling for the operand byte counter.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPCODE  = 2'd1,
        OPERAND = 2'd2
    } spi_state_t;

    localparam int          BYTE_BITS         = 8;
    localparam logic [31:0] OPERAND_COUNT_MAX = 32'h7FFF_FFFF;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_input_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_input_sync
// Description : Multi-flop synchroniser for one asynchronous SPI pin, plus a
//               rise/fall detector on the synchronised level.
// Ports       : clock_in   - system clock
//               reset_n_in - asynchronous active-low reset
//               i_data     - raw pin
//               o_sync     - synchronised level
//               o_rise     - one-cycle pulse on synchronised 0->1
//               o_fall     - one-cycle pulse on synchronised 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset_n_in,
    input  logic i_data,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // All flops reset low: a pin already low when reset releases therefore
    // produces no fall pulse, which is what keeps a CS held low through
    // reset from starting a transaction.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_data};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule : spi_input_sync
`default_nettype wire

// File: rtl/spi_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : spi_peripheral
// Description : SPI mode-0 target front-end, oversampled in the clock_in
//               domain. First byte of a transaction is the opcode, each
//               further byte is an operand strobe. Response bytes are
//               shifted out on CIPO, MSB first.
// Ports       : clock_in, reset_n_in            - clock, async active-low reset
//               spi_sck_in/cs_n_in/copi_in      - SPI pins from the host
//               spi_cipo_out                    - SPI data to the host
//               op_code_out/op_code_valid_out   - captured opcode
//               operand_out/operand_valid_out   - operand byte + 1-cycle strobe
//               operand_count_out               - operand bytes since opcode
//               response_in/response_valid_in   - byte to return to the host
// Revision    : 1.0 - initial release
// ============================================================================
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock_in,
    input  logic        reset_n_in,
    input  logic        spi_sck_in,
    input  logic        spi_cs_n_in,
    input  logic        spi_copi_in,
    output logic        spi_cipo_out,
    output logic [7:0]  op_code_out,
    output logic        op_code_valid_out,
    output logic [7:0]  operand_out,
    output logic        operand_valid_out,
    output logic [31:0] operand_count_out,
    input  logic [7:0]  response_in,
    input  logic        response_valid_in
);

    localparam logic [2:0] c_last_bit = 3'(BYTE_BITS - 1);

    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_sck_unused_sync;
    logic       w_cs_sync;
    logic       w_cs_fall;
    logic       w_cs_unused_rise;
    logic       w_copi_sync;
    logic       w_copi_unused_rise;
    logic       w_copi_unused_fall;

    spi_state_t r_state;
    spi_state_t w_state_next;
    logic [2:0] r_bit_cnt;
    // Only the low seven bits are stored; the complete byte is w_rx_next on
    // the cycle the eighth bit arrives.
    logic [6:0] r_rx;
    logic [7:0] w_rx_next;
    logic [7:0] r_tx;
    logic       r_load_pending;
    logic       w_byte_done;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .i_data     (spi_sck_in),
        .o_sync     (w_sck_unused_sync),
        .o_rise     (w_sck_rise),
        .o_fall     (w_sck_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .i_data     (spi_cs_n_in),
        .o_sync     (w_cs_sync),
        .o_rise     (w_cs_unused_rise),
        .o_fall     (w_cs_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_copi_sync (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .i_data     (spi_copi_in),
        .o_sync     (w_copi_sync),
        .o_rise     (w_copi_unused_rise),
        .o_fall     (w_copi_unused_fall)
    );

    assign w_rx_next   = {r_rx, w_copi_sync};
    assign w_byte_done = w_sck_rise && (r_bit_cnt == c_last_bit);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. CS high is checked first so that it beats an SCK
    // rise synchronised on the same cycle. A new transaction needs a CS
    // falling edge, not merely a low level.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_cs_sync) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_cs_fall)   w_state_next = OPCODE;
                OPCODE:  if (w_byte_done) w_state_next = OPERAND;
                OPERAND: w_state_next = OPERAND;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: shift registers, byte capture, counter and CIPO shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_bit_cnt         <= '0;
            r_rx              <= '0;
            r_tx              <= '0;
            r_load_pending    <= 1'b0;
            op_code_out       <= '0;
            op_code_valid_out <= 1'b0;
            operand_out       <= '0;
            operand_valid_out <= 1'b0;
            operand_count_out <= '0;
        end else if (w_cs_sync) begin
            // Partial byte is dropped; captured bytes are kept for the consumer.
            r_bit_cnt         <= '0;
            r_rx              <= '0;
            r_tx              <= '0;
            r_load_pending    <= 1'b0;
            op_code_valid_out <= 1'b0;
            operand_valid_out <= 1'b0;
            operand_count_out <= '0;
        end else begin
            operand_valid_out <= 1'b0;
            if (r_state == IDLE) begin
                r_bit_cnt         <= '0;
                r_rx              <= '0;
                r_tx              <= '0;
                r_load_pending    <= 1'b0;
                operand_count_out <= '0;
            end else begin
                if (w_sck_rise) begin
                    r_rx <= w_rx_next[6:0];
                    if (r_bit_cnt == c_last_bit) begin
                        r_bit_cnt      <= '0;
                        r_load_pending <= 1'b1;
                        if (r_state == OPCODE) begin
                            op_code_out       <= w_rx_next;
                            op_code_valid_out <= 1'b1;
                        end else begin
                            operand_out       <= w_rx_next;
                            operand_valid_out <= 1'b1;
                            if (operand_count_out != OPERAND_COUNT_MAX) begin
                                operand_count_out <= operand_count_out + 32'd1;
                            end
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                // The first fall after a byte boundary loads the response so
                // its MSB is on CIPO before the host's next sampling rise.
                if (w_sck_fall) begin
                    if (r_load_pending) begin
                        r_tx           <= response_valid_in ? response_in : 8'h00;
                        r_load_pending <= 1'b0;
                    end else begin
                        r_tx <= {r_tx[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi_cipo_out = ~w_cs_sync & r_tx[7];

endmodule : spi_peripheral
`default_nettype wire

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI target front-end. Deserialises host (MCU) SPI traffic into opcode/operand strobes for the camera register block.
- Serialises that block's response bytes back onto CIPO.
- Sits between the FPGA SPI pins and the register decoder. All SPI inputs are oversampled in the clock_in domain; there is no SCK clock domain.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers for sck/cs/copi (minimum 2).

Ports:
- clock_in  input  1  system clock; must run at ≥8× SCK frequency.
- reset_n_in  input  1  reset, asynchronous active-low.
- spi_sck_in  input  1  SPI clock, mode 0, idle low.
- spi_cs_n_in  input  1  chip select, active-low.
- spi_copi_in  input  1  controller-out data, MSB first.
- spi_cipo_out  output  1  peripheral-out data, MSB first.
- op_code_out  output  8  first byte of current transaction.
- op_code_valid_out  output  1  high from opcode capture until CS deasserts.
- operand_out  output  8  most recent complete operand byte.
- operand_valid_out  output  1  one-cycle pulse per completed operand byte.
- operand_count_out  output  32  completed operand bytes since opcode (integer).
- response_in  input  8  byte to return during the current/next operand byte.
- response_valid_in  input  1  response_in is meaningful.

Behaviour:
- Reset (async assert, sync deassert), all outputs 0:
  - op_code_out=0, op_code_valid_out=0, operand_out=0, operand_valid_out=0, operand_count_out=0, spi_cipo_out=0.
  - State IDLE, bit counter 0, shift registers 0.
- Input synchronisation:
  - sck, cs_n and copi each pass through SYNC_STAGES flops.
  - A registered copy of synced sck gives rise and fall pulses.
  - Synced cs_n falling/rising gives start/stop.
- State machine (enum in package):
  - IDLE: wait for synced cs_n low → OPCODE. Clear bit counter and operand_count_out.
  - OPCODE: on each SCK rise, shift copi into rx[7:0] MSB first and increment bit counter.
  - OPCODE, 8th rise: op_code_out<=rx next value, op_code_valid_out<=1, bit counter<=0, → OPERAND. Latency is 1 cycle after the synced rise.
  - OPERAND: on each SCK rise, shift as above.
  - OPERAND, 8th rise: operand_out<=byte, operand_valid_out<=1 for exactly one cycle, operand_count_out<=operand_count_out+1 on that same cycle, bit counter<=0.
  - Any state, synced cs_n high: → IDLE. Clear op_code_valid_out, operand_count_out and bit counter. operand_out and op_code_out hold their values. Partial byte discarded; no operand_valid pulse.
- CIPO path:
  - tx shift register is loaded on the first SCK fall after each byte boundary: after the opcode byte's 8th rise, and after each operand byte's 8th rise.
  - Loaded value is response_in if response_valid_in, else 8'h00.
  - spi_cipo_out = tx[7] while cs_n low. tx shifts left on each subsequent SCK fall.
  - spi_cipo_out is 0 while cs_n high. During the opcode byte, tx=0.
  - Consumer timing: the consumer sees the new op_code_valid/operand_count at least 2 clocks before the load. This is guaranteed by the ≥8× oversampling ratio.
- Boundaries:
  - operand_count_out saturates at 2^31-1 (no wrap).
  - CS high and SCK rise synchronised in the same cycle: CS wins; the bit is dropped.
  - CS low with SCK high at entry: no false rise. The edge detector's reset value equals the synced sck on entry to OPCODE.
  - Reset mid-transaction: immediate return to reset values. The next transaction requires a fresh CS falling edge; CS low already at reset release is ignored until it goes high once.
  - Zero-operand transaction (opcode then CS high): no operand_valid pulse; op_code_valid drops after CS.

Decomposition:
- Package spi_pkg: state enum (IDLE, OPCODE, OPERAND), BYTE_BITS=8 constant, and OPERAND_COUNT_MAX constant.
- Sub-module spi_input_sync: parameterised SYNC_STAGES synchroniser plus rise/fall detector. Instantiated for sck and cs_n; copi uses the synchroniser only.

Test Plan:
- Opcode only: CS low, send 0x27, CS high → op_code_out=0x27 and op_code_valid=1 after 8th rise; valid=0 after CS high; operand_count stays 0; no operand_valid pulse.
- Write: send 0x23,0x01,0x40 → two operand_valid pulses. Pulse 1: operand_out=0x01, count=1. Pulse 2: operand_out=0x40, count=2.
- Read: send 0x21 then two dummy bytes. Bench drives response_in=0xAB for count 0 and 0xCD for count 1, both with response_valid_in=1 → CIPO shows 0xAB then 0xCD, MSB first.
- response_valid_in=0 during read → CIPO bytes = 0x00.
- Abort: CS high after 5 operand bits → no operand_valid pulse and count unchanged. Next transaction 0x20 decodes correctly from bit 0.
- Async reset asserted mid-operand byte → all outputs 0 immediately, without waiting for a clock edge. With CS held low through release, no decode occurs until a CS high→low sequence.
